// File: rtl/multi_sig_timestamp.sv
// rtl/multi_sig_timestamp.sv - multi-channel synchronised edge timestamper with event FIFO
module multi_sig_timestamp #(
    parameter int NCH         = 4,
    parameter int TS_W        = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NCH-1:0]  sig_in,
    input  logic            sync_start,
    input  logic [1:0]      edge_mode,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [TS_W-1:0] evt_time,
    output logic [CW-1:0]   evt_chan,
    output logic            evt_rising,
    output logic [LW-1:0]   fifo_level,
    output logic            overflow,
    input  logic            clear_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    // Scan timer
    logic [TS_W-1:0] timer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (sync_start) begin
            timer <= '0;
        end else begin
            timer <= timer + TS_W'(1);
        end
    end

    // Synchroniser chain; cur is the synchronised sample judged this cycle,
    // prev the one judged last cycle. Detection lands SYNC_STAGES+1 cycles
    // after sig_in is first captured.
    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
    logic [NCH-1:0] cur;
    logic [NCH-1:0] prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cur    <= '0;
            prev   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            cur    <= sync_q[SYNC_STAGES-1];
            prev   <= cur;
        end
    end

    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] det;

    assign rise = cur & ~prev & {NCH{edge_mode[0]}};
    assign fall = ~cur & prev & {NCH{edge_mode[1]}};
    assign det  = rise | fall;

    // FIFO occupancy
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic          fifo_full;
    logic          pop;
    logic          can_push;

    assign fifo_level = wr_ptr - rd_ptr;
    assign evt_valid  = (fifo_level != '0);
    assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
    assign pop        = evt_valid & evt_ready;
    assign can_push   = ~fifo_full | pop;

    // Per-channel pending slots
    logic [NCH-1:0]           slot_full;
    logic [NCH-1:0]           slot_rise;
    logic [NCH-1:0][TS_W-1:0] slot_time;

    // Fixed-priority pick of the lowest occupied slot
    logic [NCH-1:0] gnt;
    logic [CW-1:0]  sel;
    logic           found;
    logic           push;
    logic [NCH-1:0] take;
    logic [NCH-1:0] drop;

    always_comb begin
        gnt   = '0;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (slot_full[i] && !found) begin
                gnt[i] = 1'b1;
                sel    = CW'(i);
                found  = 1'b1;
            end
        end
    end

    assign push = found & can_push;
    assign take = push ? gnt : '0;
    // A slot being drained this cycle can accept a fresh edge
    assign drop = det & slot_full & ~take;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_full <= '0;
            slot_rise <= '0;
            slot_time <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (det[i] && (!slot_full[i] || take[i])) begin
                    slot_full[i] <= 1'b1;
                    slot_rise[i] <= rise[i];
                    slot_time[i] <= timer;
                end else if (take[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    // Drop beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (|drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    // Event storage
    logic [TS_W-1:0] mem_time [FIFO_DEPTH];
    logic [CW-1:0]   mem_chan [FIFO_DEPTH];
    logic            mem_rise [FIFO_DEPTH];
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_time[wr_idx] <= slot_time[sel];
            mem_chan[wr_idx] <= sel;
            mem_rise[wr_idx] <= slot_rise[sel];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LW'(1);
            end
        end
    end

    // Head is forced to zero while empty so outputs are defined out of reset
    assign evt_time   = evt_valid ? mem_time[rd_idx] : '0;
    assign evt_chan   = evt_valid ? mem_chan[rd_idx] : '0;
    assign evt_rising = evt_valid ? mem_rise[rd_idx] : 1'b0;

endmodule

// File: tb/tb_multi_sig_timestamp.sv
// tb/tb_multi_sig_timestamp.sv - directed and randomized bench for multi_sig_timestamp
module tb_multi_sig_timestamp;
    localparam int NCH   = 4;
    localparam int TS_W  = 8;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NCH-1:0]  sig_in;
    logic            sync_start;
    logic [1:0]      edge_mode;
    logic            evt_valid;
    logic            evt_ready;
    logic [TS_W-1:0] evt_time;
    logic [1:0]      evt_chan;
    logic            evt_rising;
    logic [4:0]      fifo_level;
    logic            overflow;
    logic            clear_overflow;

    multi_sig_timestamp #(
        .NCH(NCH), .TS_W(TS_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .sync_start(sync_start),
        .edge_mode(edge_mode), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_time(evt_time), .evt_chan(evt_chan), .evt_rising(evt_rising),
        .fifo_level(fifo_level), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;
    int t0    = 0;

    typedef struct {
        int         ch;
        logic       r;
        logic [7:0] t;
    } ev_t;

    ev_t mq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Timer value in the detection cycle of an input driven at negedge of cycle c
    function automatic logic [7:0] stamp(input int c);
        return 8'(c + 3 - t0);
    endfunction

    task automatic do_sync();
        sync_start = 1'b1;
        t0 = cyc + 1;
        tick();
        sync_start = 1'b0;
    endtask

    task automatic quiesce();
        edge_mode = 2'b00;
        sig_in    = '0;
        tick(8);
    endtask

    task automatic pop_expect(input string tag, input int ch, input logic r,
                              input logic [7:0] t, output logic [7:0] obs_t);
        int w = 0;
        while (evt_valid !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        chk({tag, "_valid"}, 32'(evt_valid), 1);
        chk({tag, "_chan"}, 32'(evt_chan), 32'(ch));
        chk({tag, "_rising"}, 32'(evt_rising), 32'(r));
        chk({tag, "_time"}, 32'(evt_time), 32'(t));
        obs_t = evt_time;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int c2;
        int w;
        int gap;
        int ch;
        int idx;
        logic [7:0] ot;
        logic [7:0] ot2;
        logic [7:0] e3;
        ev_t ev;

        reset_n        = 1'b0;
        sig_in         = '0;
        sync_start     = 1'b0;
        edge_mode      = 2'b00;
        evt_ready      = 1'b0;
        clear_overflow = 1'b0;
        tick(3);
        chk("reset_valid", 32'(evt_valid), 0);
        chk("reset_level", 32'(fifo_level), 0);
        chk("reset_ovf", 32'(overflow), 0);
        chk("reset_time", 32'(evt_time), 0);
        reset_n   = 1'b1;
        edge_mode = 2'b01;
        tick(2);

        // Single rising edge on ch2, ten cycles after the scan start
        do_sync();
        tick(10);
        sig_in[2] = 1'b1;
        tick(4);
        chk("t1_early_valid", 32'(evt_valid), 0);
        tick();
        chk("t1_valid_latency", 32'(evt_valid), 1);
        chk("t1_level", 32'(fifo_level), 1);
        pop_expect("t1", 2, 1'b1, 8'd13, ot);
        chk("t1_level_after", 32'(fifo_level), 0);

        // Mode off suppresses new events
        edge_mode = 2'b00;
        sig_in[2] = 1'b0;
        tick(8);
        chk("t1_off_valid", 32'(evt_valid), 0);

        // Five-cycle pulse in both-edge mode
        edge_mode = 2'b11;
        tick();
        sig_in[0] = 1'b1;
        c = cyc;
        tick(5);
        sig_in[0] = 1'b0;
        c2 = cyc;
        pop_expect("t2_rise", 0, 1'b1, stamp(c), ot);
        pop_expect("t2_fall", 0, 1'b0, stamp(c2), ot2);
        chk("t2_diff", 32'(8'(ot2 - ot)), 5);

        // All channels rise together
        edge_mode = 2'b01;
        tick();
        sig_in = 4'hF;
        c = cyc;
        w = 0;
        while (evt_valid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        evt_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            chk("t3_valid", 32'(evt_valid), 1);
            chk("t3_chan", 32'(evt_chan), 32'(i));
            chk("t3_time", 32'(evt_time), 32'(stamp(c)));
            chk("t3_rising", 32'(evt_rising), 1);
            tick();
        end
        evt_ready = 1'b0;
        chk("t3_level", 32'(fifo_level), 0);

        // Fill the FIFO, then overrun the ch1 slot
        quiesce();
        edge_mode = 2'b11;
        mq.delete();
        for (int i = 0; i < 16; i++) begin
            ch = i % 4;
            sig_in[ch] = ~sig_in[ch];
            mq.push_back('{ch: ch, r: sig_in[ch], t: stamp(cyc)});
            tick(2);
        end
        tick(8);
        chk("t4_level_full", 32'(fifo_level), 16);
        chk("t4_ovf_before", 32'(overflow), 0);
        for (int j = 0; j < 3; j++) begin
            sig_in[1] = ~sig_in[1];
            if (j == 0) mq.push_back('{ch: 1, r: sig_in[1], t: stamp(cyc)});
            tick(3);
        end
        tick(6);
        chk("t4_level_held", 32'(fifo_level), 16);
        chk("t4_ovf_set", 32'(overflow), 1);
        for (int k = 0; k < 17; k++) begin
            ev = mq.pop_front();
            pop_expect("t4_drain", ev.ch, ev.r, ev.t, ot);
        end
        chk("t4_level_empty", 32'(fifo_level), 0);
        chk("t4_ovf_sticky", 32'(overflow), 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("t4_ovf_cleared", 32'(overflow), 0);

        // Timer wrap and sync_start in the detection cycle
        quiesce();
        edge_mode = 2'b11;
        do_sync();
        tick(251);
        sig_in[0] = 1'b1;
        tick();
        sig_in[1] = 1'b1;
        tick();
        sig_in[2] = 1'b1;
        pop_expect("t5_wrap254", 0, 1'b1, 8'd254, ot);
        pop_expect("t5_wrap255", 1, 1'b1, 8'd255, ot);
        pop_expect("t5_wrap0", 2, 1'b1, 8'd0, ot);
        tick();
        sig_in[3] = 1'b1;
        c = cyc;
        e3 = stamp(c);
        tick(3);
        sync_start = 1'b1;
        tick();
        sync_start = 1'b0;
        t0 = c + 4;
        tick();
        sig_in[0] = 1'b0;
        pop_expect("t5_sync_det", 3, 1'b1, e3, ot);
        pop_expect("t5_after_sync", 0, 1'b0, 8'd4, ot);

        // Competing double edges, then async reset with five entries queued
        quiesce();
        edge_mode = 2'b11;
        tick();
        sig_in = 4'hF;
        c = cyc;
        tick();
        sig_in = 4'h0;
        w = 0;
        while (fifo_level != 5'd5 && w < 40) begin
            tick();
            w++;
        end
        chk("t6_level", 32'(fifo_level), 5);
        chk("t6_ovf", 32'(overflow), 1);
        chk("t6_head_chan", 32'(evt_chan), 0);
        chk("t6_head_rising", 32'(evt_rising), 1);
        chk("t6_head_time", 32'(evt_time), 32'(stamp(c)));
        evt_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(evt_valid), 0);
        chk("t6_rst_level", 32'(fifo_level), 0);
        chk("t6_rst_ovf", 32'(overflow), 0);
        evt_ready = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        chk("t6_post_valid", 32'(evt_valid), 0);
        chk("t6_post_level", 32'(fifo_level), 0);

        // Randomized toggles against a per-channel ordered event list
        mq.delete();
        edge_mode = 2'b11;
        do_sync();
        gap = 2;
        for (int i = 0; i < 400; i++) begin
            evt_ready = ($urandom_range(0, 3) != 0);
            if (evt_valid === 1'b1 && evt_ready) begin
                idx = -1;
                for (int k = 0; k < mq.size(); k++) begin
                    if (idx < 0 && mq[k].ch == int'(evt_chan)) idx = k;
                end
                if (idx < 0) begin
                    chk("rnd_unexpected_chan", 32'(evt_chan), 32'hFF);
                end else begin
                    chk("rnd_time", 32'(evt_time), 32'(mq[idx].t));
                    chk("rnd_rising", 32'(evt_rising), 32'(mq[idx].r));
                    mq.delete(idx);
                end
            end
            if (gap == 0) begin
                ch = $urandom_range(0, NCH - 1);
                sig_in[ch] = ~sig_in[ch];
                mq.push_back('{ch: ch, r: sig_in[ch], t: stamp(cyc)});
                gap = $urandom_range(4, 7);
            end else begin
                gap--;
            end
            tick();
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (evt_valid === 1'b1) begin
                idx = -1;
                for (int k = 0; k < mq.size(); k++) begin
                    if (idx < 0 && mq[k].ch == int'(evt_chan)) idx = k;
                end
                if (idx < 0) begin
                    chk("rnd_drain_unexpected_chan", 32'(evt_chan), 32'hFF);
                end else begin
                    chk("rnd_drain_time", 32'(evt_time), 32'(mq[idx].t));
                    chk("rnd_drain_rising", 32'(evt_rising), 32'(mq[idx].r));
                    mq.delete(idx);
                end
            end
            tick();
        end
        evt_ready = 1'b0;
        chk("rnd_left", 32'(mq.size()), 0);
        chk("rnd_level", 32'(fifo_level), 0);
        chk("rnd_ovf", 32'(overflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
